// File: rtl/sync_gen_ctrl.sv
// sync_gen_ctrl: turns the software control word into datapath sync pulses.
// It supports one-shot or periodic operation, started by a software arm or by an
// external trigger, and reports armed/running state and a wrapping pulse count.
module sync_gen_ctrl #(
  parameter int unsigned PERIOD_W = 32,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  input  logic [31:0]         ctrl_word,
  input  logic [PERIOD_W-1:0] period,
  input  logic                ext_trig,
  output logic                sync_out,
  output logic                armed,
  output logic                running,
  output logic [CNT_W-1:0]    sync_count
);

  typedef enum logic [1:0] {StIdle, StArmed, StPulse, StGap} state_e;

  // Only arm/continuous/ext/abort and the pulse length are meaningful.
  logic [3:0]          ctrl_q;
  logic [7:0]          len_ctrl_q;
  logic                arm_prev_q;
  logic                ext_meta_q, ext_sync_q, ext_prev_q;
  logic                unused_ctrl;

  state_e              state_q;
  logic [7:0]          len_q;
  logic [PERIOD_W-1:0] per_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic                sync_out_q, armed_q, running_q;
  logic [CNT_W-1:0]    sync_count_q;

  logic                arm_edge, ext_rise, go_pulse;
  logic [7:0]          eff_len;
  logic [PERIOD_W-1:0] min_per, eff_per;

  assign unused_ctrl = ^{ctrl_word[31:16], ctrl_word[7:4]};

  // Register the control word and synchronise the external trigger.
  // Arm bits reset high so an arm held through reset release does not fire.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ctrl_q     <= 4'b0001;
      len_ctrl_q <= 8'd0;
      arm_prev_q <= 1'b1;
      ext_meta_q <= 1'b0;
      ext_sync_q <= 1'b0;
      ext_prev_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_word[3:0];
      len_ctrl_q <= ctrl_word[15:8];
      arm_prev_q <= ctrl_q[0];
      ext_meta_q <= ext_trig;
      ext_sync_q <= ext_meta_q;
      ext_prev_q <= ext_sync_q;
    end
  end

  // Edge detects, effective length/period and the pulse-start condition.
  always_comb begin
    arm_edge = ctrl_q[0] & ~arm_prev_q;
    ext_rise = ext_sync_q & ~ext_prev_q;
    eff_len  = (len_ctrl_q == 8'd0) ? 8'd1 : len_ctrl_q;
    min_per  = PERIOD_W'(eff_len) + PERIOD_W'(1);
    eff_per  = (period > min_per) ? period : min_per;
    go_pulse = 1'b0;
    unique case (state_q)
      StIdle:  go_pulse = arm_edge & ~ctrl_q[2];
      StArmed: go_pulse = ext_rise;
      StPulse: go_pulse = 1'b0;
      StGap:   go_pulse = (cnt_q == per_q);
    endcase
  end

  // Sequencer; cnt_q counts cycles since the current pulse's rising edge (1 at entry).
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q      <= StIdle;
      len_q        <= 8'd1;
      per_q        <= '0;
      cnt_q        <= '0;
      sync_out_q   <= 1'b0;
      armed_q      <= 1'b0;
      running_q    <= 1'b0;
      sync_count_q <= '0;
    end else if (ctrl_q[3]) begin
      state_q    <= StIdle;
      sync_out_q <= 1'b0;
      armed_q    <= 1'b0;
      running_q  <= 1'b0;
    end else if (go_pulse) begin
      state_q      <= StPulse;
      len_q        <= eff_len;
      per_q        <= eff_per;
      cnt_q        <= PERIOD_W'(1);
      sync_out_q   <= 1'b1;
      armed_q      <= 1'b0;
      running_q    <= 1'b1;
      sync_count_q <= sync_count_q + CNT_W'(1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm_edge && ctrl_q[2]) begin
            state_q <= StArmed;
            armed_q <= 1'b1;
          end
        end
        StArmed: ;
        StPulse: begin
          cnt_q <= cnt_q + PERIOD_W'(1);
          if (cnt_q == PERIOD_W'(len_q)) begin
            sync_out_q <= 1'b0;
            if (ctrl_q[1]) begin
              state_q <= StGap;
            end else begin
              state_q   <= StIdle;
              running_q <= 1'b0;
            end
          end
        end
        StGap: cnt_q <= cnt_q + PERIOD_W'(1);
      endcase
    end
  end

  assign sync_out   = sync_out_q;
  assign armed      = armed_q;
  assign running    = running_q;
  assign sync_count = sync_count_q;

endmodule

// File: tb/tb_sync_gen_ctrl.sv
// Scoreboard bench for sync_gen_ctrl: stimulus pushes expected pulses
// (rising cycle, width, count at rise); a monitor pops and checks each pulse.
module tb_sync_gen_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ctrl = '0;
  logic [31:0] period = '0;
  logic        ext = 1'b0;
  logic        sync_out, armed, running;
  logic [31:0] sync_count;

  sync_gen_ctrl #(.PERIOD_W(32), .CNT_W(32)) dut (
    .user_clk   (clk),
    .user_rst_n (rst_n),
    .ctrl_word  (ctrl),
    .period     (period),
    .ext_trig   (ext),
    .sync_out   (sync_out),
    .armed      (armed),
    .running    (running),
    .sync_count (sync_count)
  );

  always #5 clk = ~clk;

  // Number of rising clock edges seen so far.
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  typedef struct {int rise; int len; int cnt;} exp_t;
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic nxt(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: sample on the falling edge, match each pulse against the queue.
  initial begin
    logic prev = 1'b0;
    logic have = 1'b0;
    int   rise = 0;
    exp_t cur;
    forever begin
      @(negedge clk);
      if (sync_out && !prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got rise at %0d expected none", cyc);
          have = 1'b0;
        end else begin
          cur  = exp_q.pop_front();
          have = 1'b1;
          rise = cyc;
          chk("rise_cycle", cyc, cur.rise);
          chk("count_at_rise", int'(sync_count), cur.cnt);
        end
      end
      if (!sync_out && prev && have) begin
        chk("pulse_width", cyc - rise, cur.len);
        have = 1'b0;
      end
      prev = sync_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int te;
    nxt(2);
    chk("rst_sync_out", int'(sync_out), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_count", int'(sync_count), 0);
    rst_n = 1'b1;
    nxt(3);

    // One-shot, length 2.
    ctrl = 32'h0000_0201;
    t = cyc + 1;
    exp_q.push_back('{rise: t + 1, len: 2, cnt: 1});
    nxt(10);
    chk("oneshot_running", int'(running), 0);
    chk("oneshot_count", int'(sync_count), 1);
    ctrl = 32'h0;
    nxt(3);

    // Continuous, period 16, length 4; clear continuous in the second gap.
    period = 32'd16;
    ctrl = 32'h0000_0403;
    t = cyc + 1;
    exp_q.push_back('{rise: t + 1, len: 4, cnt: 2});
    exp_q.push_back('{rise: t + 17, len: 4, cnt: 3});
    exp_q.push_back('{rise: t + 33, len: 4, cnt: 4});
    at(t + 24);
    ctrl = 32'h0000_0401;
    at(t + 34);
    chk("cont_last_running", int'(running), 1);
    at(t + 50);
    chk("cont_end_running", int'(running), 0);
    chk("cont_end_count", int'(sync_count), 4);
    ctrl = 32'h0;
    nxt(2);

    // External trigger wait.
    ctrl = 32'h0000_0105;
    nxt(100);
    chk("ext_armed_wait", int'(armed), 1);
    chk("ext_running_wait", int'(running), 0);
    ext = 1'b1;
    te = cyc + 1;
    exp_q.push_back('{rise: te + 2, len: 1, cnt: 5});
    at(te + 1);
    chk("ext_armed_t1", int'(armed), 1);
    at(te + 2);
    chk("ext_armed_t2", int'(armed), 0);
    chk("ext_running_t2", int'(running), 1);
    ext = 1'b0;
    ctrl = 32'h0;
    nxt(5);

    // Period clamp (2 -> 5) then abort in the gap; arm toggles ignored.
    period = 32'd2;
    ctrl = 32'h0000_0403;
    t = cyc + 1;
    exp_q.push_back('{rise: t + 1, len: 4, cnt: 6});
    exp_q.push_back('{rise: t + 6, len: 4, cnt: 7});
    at(t + 9);
    ctrl = 32'h0000_040B;
    at(t + 10);
    chk("abort_in_gap_running", int'(running), 1);
    at(t + 11);
    chk("abort_running", int'(running), 0);
    chk("abort_count", int'(sync_count), 7);
    for (int i = 0; i < 4; i++) begin
      ctrl = (i % 2 == 0) ? 32'h0000_0408 : 32'h0000_0409;
      nxt(2);
    end
    ctrl = 32'h0;
    nxt(3);
    chk("abort_arm_ignored", int'(running), 0);

    // ext_trig in IDLE ignored; re-arm and ext_trig while running ignored.
    ext = 1'b1;
    nxt(2);
    ext = 1'b0;
    nxt(4);
    chk("idle_ext_armed", int'(armed), 0);
    chk("idle_ext_running", int'(running), 0);
    period = 32'd10;
    ctrl = 32'h0000_0203;
    t = cyc + 1;
    exp_q.push_back('{rise: t + 1, len: 2, cnt: 8});
    exp_q.push_back('{rise: t + 11, len: 2, cnt: 9});
    exp_q.push_back('{rise: t + 21, len: 2, cnt: 10});
    at(t + 4);
    ctrl = 32'h0000_0202;
    at(t + 6);
    ctrl = 32'h0000_0203;
    at(t + 8);
    ext = 1'b1;
    at(t + 10);
    ext = 1'b0;
    at(t + 15);
    ctrl = 32'h0000_0201;
    at(t + 35);
    chk("rearm_running", int'(running), 0);
    chk("rearm_count", int'(sync_count), 10);
    ctrl = 32'h0;
    nxt(3);

    // Reset during a long pulse with arm held high.
    ctrl = 32'h0000_FF01;
    t = cyc + 1;
    exp_q.push_back('{rise: t + 1, len: 5, cnt: 11});
    at(t + 5);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_sync_out", int'(sync_out), 0);
    chk("midrst_running", int'(running), 0);
    chk("midrst_armed", int'(armed), 0);
    chk("midrst_count", int'(sync_count), 0);
    nxt(2);
    rst_n = 1'b1;
    nxt(30);
    chk("postrst_running", int'(running), 0);
    chk("postrst_count", int'(sync_count), 0);
    ctrl = 32'h0;
    nxt(2);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
